// File: rtl/key_step_ctrl.sv
`default_nettype none
// ============================================================================
// key_step_ctrl : debounced Left/Right keys -> direction, rate-divided step
//                 strobe and wrapping LED position index.
// Revision      : 1.0
// ============================================================================
module key_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SLOW_DIV        = 6250000,
  parameter int FAST_DIV        = 3125000,
  parameter int NUM_POS         = 10
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Left,
  input  logic                       Right,
  input  logic                       Sw,
  output logic [1:0]                 Dir,
  output logic                       Step,
  output logic [$clog2(NUM_POS)-1:0] Pos
);

  localparam int POS_W   = $clog2(NUM_POS);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_POS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RIGHT = 2'b01,
    ST_LEFT  = 2'b10
  } dir_e;

  logic [1:0] key_raw;   // [1] = Left, [0] = Right
  logic [1:0] press;
  assign key_raw = {Left, Right};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]      sync_q;
    logic            stable_q;
    logic [DB_W-1:0] cnt_q;
    logic            press_q;

    // The press pulse is registered alongside the stable flip, so the FSM
    // reacts one cycle after the debounced level changes.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        sync_q   <= 2'b11;
        stable_q <= 1'b1;
        cnt_q    <= '0;
        press_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], key_raw[k]};
        press_q <= 1'b0;
        if (sync_q[1] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
          press_q  <= stable_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[k] = press_q;
  end

  logic [1:0] sw_sync_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sw_sync_q <= 2'b11;
    end else begin
      sw_sync_q <= {sw_sync_q[0], Sw};
    end
  end

  logic lpress;
  logic rpress;
  dir_e dir_q;
  dir_e dir_d;

  assign lpress = press[1];
  assign rpress = press[0];

  always_comb begin
    dir_d = dir_q;
    if (lpress ^ rpress) begin
      unique case (dir_q)
        ST_IDLE:  dir_d = lpress ? ST_LEFT : ST_RIGHT;
        ST_LEFT:  dir_d = lpress ? ST_IDLE : ST_RIGHT;
        ST_RIGHT: dir_d = rpress ? ST_IDLE : ST_LEFT;
        default:  dir_d = ST_IDLE;
      endcase
    end
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_last;
  logic             tick;
  logic             step_q;
  logic [POS_W-1:0] pos_q;

  assign div_last = sw_sync_q[1] ? FAST_LAST : SLOW_LAST;
  // >= lets a slow-to-fast switch mid-count fire immediately instead of overrunning
  assign tick     = (div_q >= div_last);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dir_q  <= ST_IDLE;
      div_q  <= '0;
      step_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      dir_q  <= dir_d;
      step_q <= 1'b0;
      if (dir_q == ST_IDLE || dir_d != dir_q) begin
        div_q <= '0;
      end else if (tick) begin
        div_q  <= '0;
        step_q <= 1'b1;
        if (dir_q == ST_LEFT) begin
          pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end else begin
          pos_q <= (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign Dir  = dir_q;
  assign Step = step_q;
  assign Pos  = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_key_step_ctrl.sv
`default_nettype none
// ============================================================================
// tb_key_step_ctrl : scenario tasks plus random stimulus against a
//                    history-based reference model of key_step_ctrl.
// Revision         : 1.0
// ============================================================================
module tb_key_step_ctrl;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int FD = 4;
  localparam int NP = 10;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_RIGHT = 2'b01;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Left = 1'b1;
  logic       Right = 1'b1;
  logic       Sw = 1'b0;
  logic [1:0] Dir;
  logic       Step;
  logic [3:0] Pos;

  int total = 0;
  int bad   = 0;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SLOW_DIV       (SD),
    .FAST_DIV       (FD),
    .NUM_POS        (NP)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Left (Left),
    .Right(Right),
    .Sw   (Sw),
    .Dir  (Dir),
    .Step (Step),
    .Pos  (Pos)
  );

  always #5 Clk = ~Clk;

  // Reference model: raw input history per edge, outputs derived from rules.
  bit         lq[$];
  bit         rq[$];
  bit         sq[$];
  bit         m_stab_l, m_stab_r;
  bit         m_pl, m_pr;
  logic [1:0] m_dir;
  logic       m_step;
  int         m_pos;
  int         m_edge;
  int         m_anchor;

  task automatic model_reset();
    lq.delete(); rq.delete(); sq.delete();
    for (int i = 0; i < D + 2; i++) begin
      lq.push_back(1'b1); rq.push_back(1'b1); sq.push_back(1'b1);
    end
    m_stab_l = 1'b1; m_stab_r = 1'b1;
    m_pl = 1'b0; m_pr = 1'b0;
    m_dir = M_IDLE; m_step = 1'b0; m_pos = 0;
    m_edge = 0; m_anchor = 0;
  endtask

  // True when the last D synchronized samples all oppose the stable level.
  function automatic bit settles(input bit q[$], input bit stab);
    bit all_opp = 1'b1;
    for (int i = 0; i < D; i++)
      if (q[q.size() - 3 - i] == stab) all_opp = 1'b0;
    return all_opp;
  endfunction

  task automatic model_edge(input logic l, input logic r, input logic s);
    logic [1:0] nd;
    int div;
    lq.push_back(l); rq.push_back(r); sq.push_back(s);
    if (lq.size() > 32) begin
      void'(lq.pop_front()); void'(rq.pop_front()); void'(sq.pop_front());
    end
    m_edge++;
    nd = m_dir;
    if (m_pl && !m_pr)      nd = (m_dir == M_LEFT)  ? M_IDLE : M_LEFT;
    else if (m_pr && !m_pl) nd = (m_dir == M_RIGHT) ? M_IDLE : M_RIGHT;
    m_pl = 1'b0; m_pr = 1'b0;
    if (settles(lq, m_stab_l)) begin m_stab_l = ~m_stab_l; m_pl = (m_stab_l == 1'b0); end
    if (settles(rq, m_stab_r)) begin m_stab_r = ~m_stab_r; m_pr = (m_stab_r == 1'b0); end
    div = sq[sq.size() - 3] ? FD : SD;
    m_step = 1'b0;
    if (m_dir == M_IDLE || nd != m_dir) begin
      m_anchor = m_edge;
    end else if (m_edge - m_anchor >= div) begin
      m_step = 1'b1;
      m_anchor = m_edge;
      m_pos = (m_dir == M_LEFT) ? (m_pos + 1) % NP : (m_pos + NP - 1) % NP;
    end
    m_dir = nd;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge(Left, Right, Sw);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Left = 1'b1; Right = 1'b1; Sw = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Left = 1'b1; Right = 1'b1; Sw = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (Dir !== 2'b00 || Step !== 1'b0 || Pos !== 4'd0) begin
      bad++; $display("FAIL reset_hold: Dir=%b Step=%b Pos=%0d, want 00 0 0", Dir, Step, Pos);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < 6; j++) begin
      tick(); total++;
      if (Dir !== 2'b00 || Step !== 1'b0 || Pos !== 4'd0 ||
          Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL reset_idle edge=%0d: Dir=%b Step=%b Pos=%0d, want 00 0 0", m_edge, Dir, Step, Pos);
      end
    end
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 15; j++) begin
      Left = (j < 3) ? 1'b0 : 1'b1;
      tick(); total++;
      if (Dir !== 2'b00 || Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL glitch edge=%0d: Dir=%b Step=%b Pos=%0d, want Dir=00 Step=%b Pos=%0d", m_edge, Dir, Step, Pos, m_step, m_pos);
      end
    end
  endtask

  task automatic test_press_latency();
    Left = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL latency_model j=%0d: Dir=%b Step=%b Pos=%0d, want %b %b %0d", j, Dir, Step, Pos, m_dir, m_step, m_pos);
      end
      if (j == 6) begin
        total++;
        if (Dir !== 2'b00) begin bad++; $display("FAIL latency_early: Dir=%b at cycle 6, want 00", Dir); end
      end
      if (j == 7) begin
        total++;
        if (Dir !== 2'b10) begin bad++; $display("FAIL latency_exact: Dir=%b at cycle 7, want 10", Dir); end
      end
    end
  endtask

  task automatic test_slow_wrap();
    int last = -1, first = -1, nsteps = 0;
    bit seen9 = 1'b0, wrapped = 1'b0;
    Left = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL slow_model j=%0d: Dir=%b Step=%b Pos=%0d, want %b %b %0d", j, Dir, Step, Pos, m_dir, m_step, m_pos);
      end
      if (Step === 1'b1) begin
        nsteps++;
        if (first < 0) first = j;
        else begin
          total++;
          if (j - last != SD) begin bad++; $display("FAIL slow_period: spacing=%0d, want %0d", j - last, SD); end
        end
        if (Pos === 4'd0 && seen9) wrapped = 1'b1;
        seen9 = (Pos === 4'd9);
        last = j;
      end
    end
    total++;
    if (first != SD) begin bad++; $display("FAIL slow_first_step: at %0d cycles, want %0d", first, SD); end
    total++;
    if (!wrapped || nsteps != 12) begin
      bad++; $display("FAIL slow_wrap: wrapped=%0d steps=%0d, want 1 12", wrapped, nsteps);
    end
  endtask

  task automatic test_fast();
    int last = -1, first = -1;
    Sw = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL fast_model j=%0d: Dir=%b Step=%b Pos=%0d, want %b %b %0d", j, Dir, Step, Pos, m_dir, m_step, m_pos);
      end
      if (Step === 1'b1) begin
        if (first < 0) first = j;
        else begin
          total++;
          if (j - last != FD) begin bad++; $display("FAIL fast_period: spacing=%0d, want %0d", j - last, FD); end
        end
        last = j;
      end
    end
    total++;
    if (first < 1 || first > 2 + FD) begin
      bad++; $display("FAIL fast_first_step: at %0d cycles after Sw, want 1..%0d", first, 2 + FD);
    end
    Sw = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL fast_back_model: Dir=%b Step=%b Pos=%0d, want %b %b %0d", Dir, Step, Pos, m_dir, m_step, m_pos);
      end
    end
  endtask

  task automatic test_reverse();
    int exp_pos[4] = '{1, 0, 9, 8};
    bit found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL reverse_wait_model: Dir=%b Step=%b Pos=%0d, want %b %b %0d", Dir, Step, Pos, m_dir, m_step, m_pos);
      end
      if (Step === 1'b1 && Pos === 4'd2) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL reverse_timeout: no step to Pos=2, want one within 200 cycles"); end
    Right = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL reverse_press_model: Dir=%b Step=%b Pos=%0d, want %b %b %0d", Dir, Step, Pos, m_dir, m_step, m_pos);
      end
    end
    total++;
    if (Dir !== 2'b01 || Pos !== 4'd2) begin
      bad++; $display("FAIL reverse_dir: Dir=%b Pos=%0d, want 01 2", Dir, Pos);
    end
    for (int j = 1; j <= 32; j++) begin
      if (j == 10) Right = 1'b1;
      tick(); total++;
      if (j % SD == 0) begin
        if (Step !== 1'b1 || Pos !== 4'(exp_pos[j / SD - 1])) begin
          bad++; $display("FAIL reverse_step j=%0d: Step=%b Pos=%0d, want 1 %0d", j, Step, Pos, exp_pos[j / SD - 1]);
        end
      end else if (Step !== 1'b0 || Dir !== m_dir || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL reverse_gap j=%0d: Step=%b Pos=%0d, want 0 %0d", j, Step, Pos, m_pos);
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [3:0] held;
    Right = 1'b0;
    repeat (7) tick();
    total++;
    if (Dir !== 2'b00 || Dir !== m_dir || Pos !== 4'(m_pos)) begin
      bad++; $display("FAIL pause_dir: Dir=%b Pos=%0d, want 00 %0d", Dir, Pos, m_pos);
    end
    held = Pos;
    Right = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick(); total++;
      if (Step !== 1'b0 || Pos !== held || Dir !== 2'b00 || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL pause_hold j=%0d: Dir=%b Step=%b Pos=%0d, want 00 0 %0d", j, Dir, Step, Pos, held);
      end
    end
    Left = 1'b0;
    repeat (7) tick();
    total++;
    if (Dir !== 2'b10 || Pos !== held || Step !== m_step) begin
      bad++; $display("FAIL resume: Dir=%b Pos=%0d, want 10 %0d", Dir, Pos, held);
    end
    Left = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(); total++;
      if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL resume_model: Dir=%b Step=%b Pos=%0d, want %b %b %0d", Dir, Step, Pos, m_dir, m_step, m_pos);
      end
    end
  endtask

  task automatic test_simultaneous();
    Left = 1'b0; Right = 1'b0;
    for (int j = 0; j < 15; j++) begin
      tick(); total++;
      if (Dir !== 2'b10 || Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL simultaneous j=%0d: Dir=%b Step=%b Pos=%0d, want 10 %b %0d", j, Dir, Step, Pos, m_step, m_pos);
      end
    end
    Left = 1'b1; Right = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    logic [3:0] held;
    Left = 1'b0;
    repeat (7) tick();
    Left = 1'b1;
    repeat (10) tick();
    total++;
    if (Dir !== 2'b00) begin bad++; $display("FAIL bounce_setup: Dir=%b, want 00", Dir); end
    held = Pos;
    for (int j = 0; j < 30; j++) begin
      Right = (j < 20 && ((j / 2) % 2 == 0)) ? 1'b0 : 1'b1;
      tick(); total++;
      if (Dir !== 2'b00 || Step !== 1'b0 || Pos !== held || Pos !== 4'(m_pos)) begin
        bad++; $display("FAIL bounce j=%0d: Dir=%b Step=%b Pos=%0d, want 00 0 %0d", j, Dir, Step, Pos, held);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 150; seg++) begin
      Left  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      Right = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      Sw    = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 12);
      for (int j = 0; j < hold; j++) begin
        tick(); total++;
        if (Dir !== m_dir || Step !== m_step || Pos !== 4'(m_pos)) begin
          bad++; $display("FAIL random edge=%0d: Dir=%b Step=%b Pos=%0d, want %b %b %0d", m_edge, Dir, Step, Pos, m_dir, m_step, m_pos);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    Left = 1'b0;
    repeat (7) tick();
    Left = 1'b1;
    repeat (20) tick();
    total++;
    if (Dir !== 2'b10 || Pos !== 4'(m_pos) || Pos === 4'd0) begin
      bad++; $display("FAIL async_setup: Dir=%b Pos=%0d, want 10 %0d", Dir, Pos, m_pos);
    end
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if (Dir !== 2'b00 || Step !== 1'b0 || Pos !== 4'd0) begin
      bad++; $display("FAIL async_reset: Dir=%b Step=%b Pos=%0d before next edge, want 00 0 0", Dir, Step, Pos);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < 12; j++) begin
      tick(); total++;
      if (Dir !== 2'b00 || Step !== 1'b0 || Pos !== 4'd0 || Dir !== m_dir) begin
        bad++; $display("FAIL async_release j=%0d: Dir=%b Step=%b Pos=%0d, want 00 0 0", j, Dir, Step, Pos);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_press_latency();
    test_slow_wrap();
    test_fast();
    test_reverse();
    test_pause_resume();
    test_simultaneous();
    test_bounce();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
